// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM: data port has priority,
// fetch is forced in after STARVE_LIMIT consecutive data grants while it waits.
module sram_port_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        sram_cs,
    output logic        sram_oe,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout,
    output logic        busy
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_starve;
    logic         r_owner_d;
    logic         r_we;
    logic         r_err;
    logic [31:0]  r_sram_addr;
    logic [31:0]  r_sram_din;
    logic [31:0]  r_i_rdata;
    logic [31:0]  r_d_rdata;

    logic w_grant_d;
    logic w_grant_f;
    logic w_misalign;
    logic w_last;
    logic w_starved;

    assign w_starved  = (r_starve == SW'(STARVE_LIMIT));
    assign w_grant_d  = d_req && !(i_req && w_starved);
    assign w_grant_f  = i_req && !w_grant_d;
    assign w_misalign = (d_addr[1:0] != 2'b00);
    assign w_last     = (r_cnt == CW'(ACCESS_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d && w_misalign)
                    w_state_next = ST_DONE;
                else if (w_grant_d || w_grant_f)
                    w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_last)
                    w_state_next = ST_DONE;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_owner_d   <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_sram_addr <= '0;
            r_sram_din  <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    // Starvation count only advances while fetch is actually waiting.
                    if (!i_req || w_grant_f)
                        r_starve <= '0;
                    else if (w_grant_d && !w_starved)
                        r_starve <= r_starve + SW'(1);

                    if (w_grant_d) begin
                        r_owner_d <= 1'b1;
                        r_we      <= d_we;
                        r_err     <= w_misalign;
                        r_cnt     <= '0;
                        // A rejected misaligned access leaves the SRAM bus untouched.
                        if (!w_misalign) begin
                            r_sram_addr <= d_addr;
                            r_sram_din  <= d_wdata;
                        end
                    end else if (w_grant_f) begin
                        r_owner_d   <= 1'b0;
                        r_we        <= 1'b0;
                        r_err       <= 1'b0;
                        r_cnt       <= '0;
                        r_sram_addr <= i_addr;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last && !r_we) begin
                        if (r_owner_d)
                            r_d_rdata <= sram_dout;
                        else
                            r_i_rdata <= sram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sram_cs   = (r_state == ST_ACCESS);
    assign sram_oe   = (r_state == ST_ACCESS) && !r_we;
    assign sram_we   = (r_state == ST_ACCESS) && r_we;
    assign sram_addr = r_sram_addr;
    assign sram_din  = r_sram_din;
    assign i_ack     = (r_state == ST_DONE) && !r_owner_d;
    assign d_ack     = (r_state == ST_DONE) && r_owner_d;
    assign d_err     = (r_state == ST_DONE) && r_owner_d && r_err;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: drivers queue expected acks, a monitor
// pops and compares them whenever i_ack or d_ack pulses.
module tb_sram_port_arbiter;

    localparam int AC = 2;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        sram_cs;
    logic        sram_oe;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;
    logic        busy;

    sram_port_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: combinational read, write on clock edge.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h20020004;
        end else if (sram_cs && sram_we) begin
            mem[sram_addr[9:2]] <= sram_din;
        end
    end
    assign sram_dout = (sram_cs && sram_oe) ? mem[sram_addr[9:2]] : 32'h0;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t fq[$];
    exp_t dq[$];
    int n_checks = 0;
    int n_errors = 0;
    int cs_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (sram_cs) cs_cycles++;
        if (i_ack) begin
            if (fq.size() == 0) begin
                check("unexpected i_ack", 32'd1, 32'd0);
            end else begin
                e = fq.pop_front();
                $display("fetch ack  cyc=%0d i_rdata=%08h", cyc, i_rdata);
                check("i_ack cycle", 32'(cyc), 32'(e.cyc));
                check("i_rdata", i_rdata, e.data);
            end
        end
        if (d_ack) begin
            if (dq.size() == 0) begin
                check("unexpected d_ack", 32'd1, 32'd0);
            end else begin
                e = dq.pop_front();
                $display("data ack   cyc=%0d d_err=%0d d_rdata=%08h", cyc, d_err, d_rdata);
                check("d_ack cycle", 32'(cyc), 32'(e.cyc));
                check("d_err", 32'(d_err), 32'(e.err));
                if (e.chk_data) check("d_rdata", d_rdata, e.data);
            end
        end
    end

    task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] exp_data, input int exp_cyc);
        exp_t e;
        bit   got;
        i_req  = 1'b1;
        i_addr = addr;
        e.data = exp_data; e.chk_data = 1'b1; e.err = 1'b0; e.cyc = exp_cyc;
        fq.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (i_ack) got = 1'b1;
        end
        if (!got) begin
            check("fetch ack timeout", 32'd0, 32'd1);
            fq.delete();
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input logic chk, input logic err,
                            input int exp_cyc);
        exp_t e;
        bit   got;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        e.data = exp_data; e.chk_data = chk; e.err = err; e.cyc = exp_cyc;
        dq.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (d_ack) got = 1'b1;
        end
        if (!got) begin
            check("data ack timeout", 32'd0, 32'd1);
            dq.delete();
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("reset ctrl/ack/busy", {25'd0, sram_cs, sram_oe, sram_we, i_ack, d_ack, d_err, busy}, 32'd0);
        check("reset i_rdata", i_rdata, 32'h0);
        check("reset d_rdata", d_rdata, 32'h0);
        check("reset sram_addr", sram_addr, 32'h0);
        @(posedge clk); #1;

        // Basic fetch with control timing
        k = cyc;
        fork
            fetch_txn(32'h0, 32'h20020004, k + AC + 1);
            begin
                @(negedge clk);
                for (int c = 1; c <= AC; c++) begin
                    @(negedge clk);
                    check("fetch cs/oe/we", {29'd0, sram_cs, sram_oe, sram_we}, 32'b110);
                    check("fetch sram_addr", sram_addr, 32'h0);
                end
                @(negedge clk);
                check("fetch done ctrl", {29'd0, sram_cs, sram_oe, sram_we}, 32'b000);
                @(negedge clk);
                check("fetch busy after", 32'(busy), 32'd0);
            end
        join
        @(posedge clk); #1;

        // Write then read back on the data port
        k = cyc;
        fork
            data_txn(1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, k + AC + 1);
            begin
                @(negedge clk);
                for (int c = 1; c <= AC; c++) begin
                    @(negedge clk);
                    check("write cs/oe/we", {29'd0, sram_cs, sram_oe, sram_we}, 32'b101);
                    check("write sram_din", sram_din, 32'hDEADBEEF);
                end
            end
        join
        check("sram after write", mem[64], 32'hDEADBEEF);
        k = cyc;
        data_txn(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, k + AC + 1);
        check("i_rdata kept", i_rdata, 32'h20020004);

        // Simultaneous requests: data first, fetch AC+2 cycles later
        k = cyc;
        fork
            data_txn(1'b0, 32'h0, 32'h0, 32'h20020004, 1'b1, 1'b0, k + AC + 1);
            fetch_txn(32'h100, 32'hDEADBEEF, k + 2 * AC + 3);
        join
        @(posedge clk); #1;

        // Starvation guard: 4 data grants, 1 fetch, then data again
        k = cyc;
        fork
            begin
                data_txn(1'b0, 32'h0,   32'h0, 32'h20020004, 1'b1, 1'b0, k + 3);
                data_txn(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, k + 7);
                data_txn(1'b0, 32'h0,   32'h0, 32'h20020004, 1'b1, 1'b0, k + 11);
                data_txn(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, k + 15);
                data_txn(1'b0, 32'h0,   32'h0, 32'h20020004, 1'b1, 1'b0, k + 23);
            end
            fetch_txn(32'h100, 32'hDEADBEEF, k + 19);
        join
        @(posedge clk); #1;

        // Misaligned write: error ack next cycle, no SRAM activity
        k  = cyc;
        n0 = cs_cycles;
        data_txn(1'b1, 32'h102, 32'h12345678, 32'h0, 1'b0, 1'b1, k + 1);
        repeat (2) @(posedge clk); #1;
        check("misaligned cs cycles", 32'(cs_cycles), 32'(n0));
        check("misaligned sram unchanged", mem[64], 32'hDEADBEEF);

        // Reset in the second ACCESS cycle of a fetch
        i_req = 1'b1; i_addr = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset cs", 32'(sram_cs), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; i_req = 1'b0;
        check("post-reset ctrl/ack/busy", {25'd0, sram_cs, sram_oe, sram_we, i_ack, d_ack, d_err, busy}, 32'd0);
        check("post-reset i_rdata", i_rdata, 32'h0);
        repeat (3) @(posedge clk); #1;
        k = cyc;
        fetch_txn(32'h0, 32'h20020004, k + AC + 1);

        repeat (3) @(posedge clk); #1;
        check("fetch queue drained", 32'(fq.size()), 32'd0);
        check("data queue drained", 32'(dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
